// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter with binary mirror, win detect and win blink.
// Feeds the seven-segment driver from point events raised by the game logic.
module score_bcd_counter #(
  parameter int WIN_SCORE    = 10,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Point,
  input  logic       i_Clear,
  output logic [3:0] o_Ones,
  output logic [3:0] o_Tens,
  output logic [6:0] o_Score,
  output logic       o_Score_Valid,
  output logic       o_Win,
  output logic       o_Blank
);

  localparam int CW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [0:0] S_PLAY = 1'b0;
  localparam logic [0:0] S_WIN  = 1'b1;

  localparam logic [6:0]    WIN_VAL    = 7'(WIN_SCORE);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

  logic [0:0]    r_State;
  logic          r_Point_d;
  logic [CW-1:0] r_Cnt;
  logic          w_Event;
  logic [3:0]    w_Nxt_Ones;
  logic [3:0]    w_Nxt_Tens;
  logic [6:0]    w_Nxt_Score;

  assign w_Event = i_Point & ~r_Point_d;
  assign o_Win   = (r_State == S_WIN);

  // Next value with decimal carry; 99 wraps to 00 on both views.
  always_comb begin
    w_Nxt_Ones  = o_Ones + 4'd1;
    w_Nxt_Tens  = o_Tens;
    w_Nxt_Score = o_Score + 7'd1;
    if (o_Ones == 4'd9) begin
      w_Nxt_Ones = 4'd0;
      if (o_Tens == 4'd9) begin
        w_Nxt_Tens  = 4'd0;
        w_Nxt_Score = 7'd0;
      end else begin
        w_Nxt_Tens = o_Tens + 4'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State       <= S_PLAY;
      r_Point_d     <= 1'b0;
      r_Cnt         <= '0;
      o_Ones        <= 4'd0;
      o_Tens        <= 4'd0;
      o_Score       <= 7'd0;
      o_Score_Valid <= 1'b0;
      o_Blank       <= 1'b0;
    end else begin
      r_Point_d     <= i_Point;
      o_Score_Valid <= 1'b0;
      case (r_State)
        S_PLAY: begin
          if (i_Clear) begin
            o_Ones        <= 4'd0;
            o_Tens        <= 4'd0;
            o_Score       <= 7'd0;
            o_Score_Valid <= 1'b1;
          end else if (w_Event) begin
            o_Ones        <= w_Nxt_Ones;
            o_Tens        <= w_Nxt_Tens;
            o_Score       <= w_Nxt_Score;
            o_Score_Valid <= 1'b1;
            if (w_Nxt_Score == WIN_VAL) begin
              r_State <= S_WIN;
              r_Cnt   <= '0;
              o_Blank <= 1'b0;
            end
          end
        end
        S_WIN: begin
          if (i_Clear) begin
            o_Ones        <= 4'd0;
            o_Tens        <= 4'd0;
            o_Score       <= 7'd0;
            o_Score_Valid <= 1'b1;
            o_Blank       <= 1'b0;
            r_Cnt         <= '0;
            r_State       <= S_PLAY;
          end else if (r_Cnt == BLINK_LAST) begin
            r_Cnt   <= '0;
            o_Blank <= ~o_Blank;
          end else begin
            r_Cnt <= r_Cnt + CW'(1);
          end
        end
        default: r_State <= S_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: three instances (win at 10, at 99, never)
// driven in lockstep and compared every cycle against an integer score model.
module tb_score_bcd_counter;

  localparam int NI = 3;
  localparam int BLINK = 4;

  logic clk;
  logic rst;
  logic point;
  logic clear;

  logic [3:0] ones  [NI];
  logic [3:0] tens  [NI];
  logic [6:0] score [NI];
  logic       valid [NI];
  logic       win   [NI];
  logic       blank [NI];

  int vectors;
  int miscompares;

  int m_score [NI];
  int m_cnt   [NI];
  bit m_win   [NI];
  bit m_blank [NI];
  bit m_valid [NI];
  bit m_pd;

  score_bcd_counter #(.WIN_SCORE(10), .BLINK_CYCLES(BLINK)) u_a (
    .i_Clk(clk), .i_Reset(rst), .i_Point(point), .i_Clear(clear),
    .o_Ones(ones[0]), .o_Tens(tens[0]), .o_Score(score[0]),
    .o_Score_Valid(valid[0]), .o_Win(win[0]), .o_Blank(blank[0])
  );

  score_bcd_counter #(.WIN_SCORE(99), .BLINK_CYCLES(BLINK)) u_b (
    .i_Clk(clk), .i_Reset(rst), .i_Point(point), .i_Clear(clear),
    .o_Ones(ones[1]), .o_Tens(tens[1]), .o_Score(score[1]),
    .o_Score_Valid(valid[1]), .o_Win(win[1]), .o_Blank(blank[1])
  );

  // Threshold beyond the 0..99 range, so this copy exercises the 99->0 wrap.
  score_bcd_counter #(.WIN_SCORE(100), .BLINK_CYCLES(BLINK)) u_c (
    .i_Clk(clk), .i_Reset(rst), .i_Point(point), .i_Clear(clear),
    .o_Ones(ones[2]), .o_Tens(tens[2]), .o_Score(score[2]),
    .o_Score_Valid(valid[2]), .o_Win(win[2]), .o_Blank(blank[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int win_of(input int i);
    case (i)
      0:       return 10;
      1:       return 99;
      default: return 100;
    endcase
  endfunction

  task automatic model_edge(input bit p, input bit c, input bit r);
    bit ev;
    ev = p && !m_pd;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_score[i] = 0; m_cnt[i] = 0;
        m_win[i] = 0; m_blank[i] = 0; m_valid[i] = 0;
      end else begin
        m_valid[i] = 0;
        if (c) begin
          m_score[i] = 0; m_valid[i] = 1;
          m_win[i] = 0; m_blank[i] = 0; m_cnt[i] = 0;
        end else if (m_win[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == BLINK) begin
            m_cnt[i] = 0;
            m_blank[i] = !m_blank[i];
          end
        end else if (ev) begin
          m_score[i] = (m_score[i] + 1) % 100;
          m_valid[i] = 1;
          if (m_score[i] == win_of(i)) begin
            m_win[i] = 1; m_cnt[i] = 0; m_blank[i] = 0;
          end
        end
      end
    end
    m_pd = r ? 1'b0 : p;
  endtask

  task automatic chk(input string tag, input int i,
                     input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, i, obs, exp);
    end
  endtask

  task automatic step(input bit p, input bit c, input bit r);
    point = p; clear = c; rst = r;
    @(posedge clk);
    model_edge(p, c, r);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("ones",  i, 32'(ones[i]),  32'(m_score[i] % 10));
      chk("tens",  i, 32'(tens[i]),  32'(m_score[i] / 10));
      chk("score", i, 32'(score[i]), 32'(m_score[i]));
      chk("valid", i, 32'(valid[i]), 32'(m_valid[i]));
      chk("win",   i, 32'(win[i]),   32'(m_win[i]));
      chk("blank", i, 32'(blank[i]), 32'(m_blank[i]));
    end
  endtask

  task automatic pulse();
    step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_pd = 0;
    for (int i = 0; i < NI; i++) begin
      m_score[i] = 0; m_cnt[i] = 0;
      m_win[i] = 0; m_blank[i] = 0; m_valid[i] = 0;
    end
    point = 0; clear = 0; rst = 1;

    repeat (3) step(0, 0, 1);
    repeat (3) pulse();
    repeat (50) step(1, 0, 0);
    step(0, 0, 0);
    repeat (6) pulse();
    repeat (14) step(0, 0, 0);
    repeat (3) pulse();
    step(0, 1, 0);
    pulse();
    repeat (4) pulse();
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    repeat (300) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 199) == 0));
    end

    step(0, 1, 0);
    repeat (99) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    pulse();
    repeat (6) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    pulse();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
